mem_port_arbiter: RTL and testbench

- Shares the single-port instruction/data memory between three requesters: data load/store (port 0), instruction fetch (port 1) and the debug/program loader (port 2).
- Serialises accesses, drives the memory port, and returns read data to the requester that issued the read.
- Uses fixed priority, with an aging override so the debug port cannot starve.
- Sits between the core controller, the loader and the memory wrapper.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, requester
// indices and the requester count.
package mem_arb_pkg;

  localparam int NPORTS = 3;

  localparam int PORT_DATA  = 0;
  localparam int PORT_FETCH = 1;
  localparam int PORT_DBG   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arbState_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: fixed priority 0 > 1 > 2, except that the
// debug port wins outright once it has lost MAX_WAIT arbitrations in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int AGE_W    = 8
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [AGE_W-1:0]  age_i,
  output logic [NPORTS-1:0] winner_o,
  output logic              valid_o
);

  logic ageExpired;

  assign ageExpired = (age_i == AGE_W'(MAX_WAIT));

  always_comb begin
    winner_o = '0;
    valid_o  = |req_i;
    if (req_i[PORT_DBG] && ageExpired) begin
      winner_o[PORT_DBG] = 1'b1;
    end else if (req_i[PORT_DATA]) begin
      winner_o[PORT_DATA] = 1'b1;
    end else if (req_i[PORT_FETCH]) begin
      winner_o[PORT_FETCH] = 1'b1;
    end else if (req_i[PORT_DBG]) begin
      winner_o[PORT_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between data (0), fetch (1) and debug (2)
// requesters; one access at a time, read data routed back to its owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [2:0]        req_i,
  input  logic [2:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [DATA_W-1:0] wdata2_i,
  output logic [2:0]        gnt_o,
  output logic [2:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int AGE_W = 8;
  localparam int CNT_W = 3;

  arbState_t         state_q, state_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic [CNT_W-1:0]  rdCnt_q, rdCnt_d;
  logic [2:0]        owner_q, owner_d;
  logic              latWe_q, latWe_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              memEn_q, memEn_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;

  logic [2:0]        winner;
  logic              winValid;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .AGE_W    (AGE_W)
  ) u_pick (
    .req_i    (req_i),
    .age_i    (age_q),
    .winner_o (winner),
    .valid_o  (winValid)
  );

  always_comb begin
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    if (winner[PORT_DATA]) begin
      selWe    = we_i[PORT_DATA];
      selAddr  = addr0_i;
      selWdata = wdata0_i;
    end else if (winner[PORT_FETCH]) begin
      selWe    = we_i[PORT_FETCH];
      selAddr  = addr1_i;
      selWdata = wdata1_i;
    end else if (winner[PORT_DBG]) begin
      selWe    = we_i[PORT_DBG];
      selAddr  = addr2_i;
      selWdata = wdata2_i;
    end
  end

  // mem_addr/mem_wdata double as the latched transaction, so they simply hold
  // after the access; only mem_en/mem_we are confined to the ACCESS cycle.
  always_comb begin
    state_d    = state_q;
    age_d      = age_q;
    rdCnt_d    = rdCnt_q;
    owner_d    = owner_q;
    latWe_d    = latWe_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    memEn_d    = 1'b0;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;

    case (state_q)
      IDLE: begin
        if (winValid) begin
          owner_d    = winner;
          latWe_d    = selWe;
          gnt_d      = winner;
          memEn_d    = 1'b1;
          memWe_d    = selWe;
          memAddr_d  = selAddr;
          memWdata_d = selWdata;
          state_d    = ACCESS;
          if (req_i[PORT_DBG] && !winner[PORT_DBG]) begin
            age_d = (age_q == AGE_W'(MAX_WAIT)) ? age_q : age_q + AGE_W'(1);
          end else begin
            age_d = '0;
          end
        end
      end
      ACCESS: begin
        if (latWe_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          rdCnt_d = CNT_W'(RD_LAT);
        end
      end
      WAIT: begin
        if (rdCnt_q == CNT_W'(1)) begin
          rdata_d  = mem_rdata_i;
          rvalid_d = owner_q;
          rdCnt_d  = '0;
          state_d  = DONE;
        end else begin
          rdCnt_d = rdCnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      age_q      <= '0;
      rdCnt_q    <= '0;
      owner_q    <= '0;
      latWe_q    <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      age_q      <= age_d;
      rdCnt_q    <= rdCnt_d;
      owner_q    <= owner_d;
      latWe_q    <= latWe_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign mem_en_o    = memEn_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a queue-level model predicts the
// grant order and read data; a monitor checks what the DUT presents.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 3;
  localparam int MAX_WAIT = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [1:0]        port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [7:0]        age;
  } exp_t;

  typedef struct packed {
    logic [1:0]        port;
    logic [DATA_W-1:0] data;
    int                due;
  } rd_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              reqB   [3];
  logic              weB    [3];
  logic [ADDR_W-1:0] addrB  [3];
  logic [DATA_W-1:0] wdataB [3];
  logic [2:0]        reqV, weV;
  logic [2:0]        gnt, rvalid;
  logic [DATA_W-1:0] rdata, memWdata, memRdata;
  logic [ADDR_W-1:0] memAddr;
  logic              busy, memEn, memWe;

  logic [DATA_W-1:0] memArr [int];
  logic [DATA_W-1:0] refMem [int];
  logic [DATA_W-1:0] pipe   [RD_LAT];

  exp_t expQ [$];
  rd_t  rdQ  [$];
  txn_t q0 [$], q1 [$], q2 [$];

  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   modelAge = 0;
  bit   monOn = 1'b0;
  exp_t monE;
  rd_t  monR;

  always #5 clock = ~clock;

  assign reqV = {reqB[2], reqB[1], reqB[0]};
  assign weV  = {weB[2], weB[1], weB[0]};

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .req_i       (reqV),
    .we_i        (weV),
    .addr0_i     (addrB[0]),
    .addr1_i     (addrB[1]),
    .addr2_i     (addrB[2]),
    .wdata0_i    (wdataB[0]),
    .wdata1_i    (wdataB[1]),
    .wdata2_i    (wdataB[2]),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .mem_en_o    (memEn),
    .mem_we_o    (memWe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_rdata_i (memRdata)
  );

  function automatic logic [DATA_W-1:0] initVal(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ 16'hA5A5;
  endfunction

  function automatic logic [DATA_W-1:0] memRead(input logic [ADDR_W-1:0] a);
    return memArr.exists(int'(a)) ? memArr[int'(a)] : initVal(a);
  endfunction

  function automatic logic [DATA_W-1:0] refRead(input logic [ADDR_W-1:0] a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : initVal(a);
  endfunction

  function automatic logic [2:0] oneHot(input logic [1:0] p);
    logic [2:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic txn_t makeTxn(input logic we, input logic [ADDR_W-1:0] a,
                                   input logic [DATA_W-1:0] d);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.wdata = d;
    return t;
  endfunction

  function automatic txn_t randTxn();
    logic [ADDR_W-1:0] a;
    a = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 31));
    return makeTxn(1'($urandom_range(0, 1)), a, DATA_W'($urandom));
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, expv, cycle);
    end
  endfunction

  // Memory wrapper stand-in: writes land at the edge, reads emerge RD_LAT edges later.
  always @(posedge clock) begin
    cycle <= cycle + 1;
    if (memEn && memWe) memArr[int'(memAddr)] = memWdata;
    pipe[0] <= (memEn && !memWe) ? memRead(memAddr) : 16'h0BAD;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign memRdata = pipe[RD_LAT-1];

  // Monitor: pops the scoreboard whenever the DUT grants or returns read data.
  always @(negedge clock) begin
    if (monOn) begin
      if (gnt != 3'b000) begin
        if (expQ.size() == 0) begin
          checkOutput("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          monE = expQ.pop_front();
          checkOutput("gnt", 32'(gnt), 32'(oneHot(monE.port)));
          checkOutput("gnt_mem_en", 32'(memEn), 32'd1);
          checkOutput("gnt_busy", 32'(busy), 32'd1);
          checkOutput("mem_we", 32'(memWe), 32'(monE.we));
          checkOutput("mem_addr", 32'(memAddr), 32'(monE.addr));
          if (monE.we) checkOutput("mem_wdata", 32'(memWdata), 32'(monE.wdata));
          checkOutput("age", 32'(dut.age_q), 32'(monE.age));
          if (!monE.we) begin
            monR.port = monE.port;
            monR.data = monE.rdata;
            monR.due  = cycle + RD_LAT + 1;
            rdQ.push_back(monR);
          end
        end
      end else begin
        checkOutput("mem_en_quiet", 32'({memEn, memWe}), 32'd0);
      end

      if (rvalid != 3'b000) begin
        if (rdQ.size() == 0) begin
          checkOutput("rvalid_unexpected", 32'(rvalid), 32'd0);
        end else begin
          monR = rdQ.pop_front();
          checkOutput("rvalid", 32'(rvalid), 32'(oneHot(monR.port)));
          checkOutput("rdata", 32'(rdata), 32'(monR.data));
          checkOutput("rvalid_latency", 32'(cycle), 32'(monR.due));
        end
      end else if (rdQ.size() > 0 && rdQ[0].due <= cycle) begin
        monR = rdQ.pop_front();
        checkOutput("rvalid_missing", 32'(rvalid), 32'(oneHot(monR.port)));
      end
    end
  end

  task automatic drivePort(input int p, input txn_t list [$]);
    int waited;
    foreach (list[i]) begin
      weB[p]    = list[i].we;
      addrB[p]  = list[i].addr;
      wdataB[p] = list[i].wdata;
      reqB[p]   = 1'b1;
      waited = 0;
      do begin
        @(negedge clock);
        waited++;
      end while (!gnt[p] && waited < 400);
      reqB[p] = 1'b0;
      checkOutput("gnt_timeout", 32'(gnt[p]), 32'd1);
      if (!gnt[p]) return;
      @(negedge clock);
    end
  endtask

  // Predicts the whole round's grant order from the queued requests, then drives it.
  task automatic applyStimulus();
    txn_t       m0 [$], m1 [$], m2 [$];
    txn_t       t;
    exp_t       e;
    logic [2:0] pend;
    int         w;
    int         waited;
    m0 = q0;
    m1 = q1;
    m2 = q2;
    while (m0.size() + m1.size() + m2.size() > 0) begin
      pend = {m2.size() > 0, m1.size() > 0, m0.size() > 0};
      if (pend[2] && modelAge == MAX_WAIT) w = 2;
      else if (pend[0]) w = 0;
      else if (pend[1]) w = 1;
      else w = 2;
      if (w == 0) t = m0.pop_front();
      else if (w == 1) t = m1.pop_front();
      else t = m2.pop_front();
      if (pend[2] && w != 2) modelAge = (modelAge == MAX_WAIT) ? MAX_WAIT : modelAge + 1;
      else modelAge = 0;
      e.port  = 2'(w);
      e.we    = t.we;
      e.addr  = t.addr;
      e.wdata = t.wdata;
      e.age   = 8'(modelAge);
      if (t.we) begin
        refMem[int'(t.addr)] = t.wdata;
        e.rdata = '0;
      end else begin
        e.rdata = refRead(t.addr);
      end
      expQ.push_back(e);
    end

    fork
      drivePort(0, q0);
      drivePort(1, q1);
      drivePort(2, q2);
    join
    q0.delete();
    q1.delete();
    q2.delete();

    waited = 0;
    while ((expQ.size() != 0 || rdQ.size() != 0 || busy) && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("drain", 32'({expQ.size() != 0, rdQ.size() != 0, busy}), 32'd0);
    expQ.delete();
    rdQ.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(rdata), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_mem_en"}, 32'(memEn), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(memWe), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(memWdata), 32'd0);
    checkOutput({tag, "_age"}, 32'(dut.age_q), 32'd0);
  endtask

  task automatic resetMidRead();
    int waited;
    monOn = 1'b0;
    weB[0]   = 1'b0;
    addrB[0] = 16'h0040;
    reqB[0]  = 1'b1;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!gnt[0] && waited < 50);
    reqB[0] = 1'b0;
    checkOutput("rst_gnt_seen", 32'(gnt[0]), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkAllZero("midreset");
    reset = 1'b0;
    modelAge = 0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      @(negedge clock);
      checkOutput("post_reset_quiet", 32'({rvalid, memEn, busy}), 32'd0);
    end
    monOn = 1'b1;
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n0, n1, n2;
    reset = 1'b1;
    for (int p = 0; p < 3; p++) begin
      reqB[p] = 1'b0;
      weB[p] = 1'b0;
      addrB[p] = '0;
      wdataB[p] = '0;
    end
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clock);
    monOn = 1'b1;

    $display("[TB] single read on fetch port");
    q2.push_back(makeTxn(1'b1, 16'h0010, 16'h1234));
    applyStimulus();
    q1.push_back(makeTxn(1'b0, 16'h0010, 16'h0000));
    applyStimulus();

    $display("[TB] write then readback on data port");
    q0.push_back(makeTxn(1'b1, 16'h0020, 16'hBEEF));
    q0.push_back(makeTxn(1'b0, 16'h0020, 16'h0000));
    applyStimulus();

    $display("[TB] contention between data and fetch reads");
    q0.push_back(makeTxn(1'b0, 16'h0030, 16'h0000));
    q1.push_back(makeTxn(1'b0, 16'h0031, 16'h0000));
    applyStimulus();

    $display("[TB] starvation guard for debug port");
    for (int i = 0; i < 3; i++) begin
      q0.push_back(makeTxn(1'b0, 16'(16'h0050 + i), 16'h0000));
      q1.push_back(makeTxn(1'b1, 16'(16'h0060 + i), 16'(16'hC000 + i)));
    end
    q2.push_back(makeTxn(1'b0, 16'h0020, 16'h0000));
    applyStimulus();

    $display("[TB] reset during read wait");
    resetMidRead();
    q0.push_back(makeTxn(1'b0, 16'h0020, 16'h0000));
    applyStimulus();

    $display("[TB] back-to-back reads on data port");
    for (int i = 0; i < 6; i++) q0.push_back(makeTxn(1'b0, 16'(i), 16'h0000));
    applyStimulus();

    $display("[TB] randomized rounds");
    for (int r = 0; r < 40; r++) begin
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      n2 = $urandom_range(0, 2);
      if (n0 + n1 + n2 == 0) n2 = 1;
      for (int i = 0; i < n0; i++) q0.push_back(randTxn());
      for (int i = 0; i < n1; i++) q1.push_back(randTxn());
      for (int i = 0; i < n2; i++) q2.push_back(randTxn());
      applyStimulus();
    end

    repeat (4) @(negedge clock);
    monOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
